// File: rtl/axi_mem_bist.sv
// rtl/axi_mem_bist.sv - AXI4 master that fills a memory region with a seeded count pattern and reads it back
module axi_mem_bist #(
  parameter int G_MAXBURST = 16,
  parameter int G_CNTWIDTH = 16
) (
  input  logic                  s_aclk,
  input  logic                  s_aresetn,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [G_CNTWIDTH-1:0] nwords,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [G_CNTWIDTH-1:0] err_count,
  output logic [31:0]           first_err_addr,
  output logic [31:0]           m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [31:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int CW = G_CNTWIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_WR_AW, S_WR_W, S_WR_B, S_RD_AR, S_RD_R, S_DONE
  } state_t;

  state_t          state_q;
  logic [31:0]     base_q, addr_q, seed_q, ferr_q;
  logic [CW-1:0]   nwords_q, rem_q, idx_q, err_q;
  logic [8:0]      beats_q, beat_q;
  logic            busy_q, done_q, pass_q;
  logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  logic [10:0]     words_4k;
  logic [8:0]      beats_d;
  logic [CW-1:0]   rem_d, err_d;
  logic [31:0]     addr_d, beat_addr, exp_word;
  logic            last_beat;
  logic [1:0]      err_inc;
  logic [CW:0]     err_sum;

  // Burst size: bounded by words remaining, the burst limit and the next 4KB page edge
  always_comb begin
    words_4k = 11'd1024 - {1'b0, addr_q[11:2]};
    beats_d  = 9'(G_MAXBURST);
    if (32'(rem_q) < 32'(beats_d)) beats_d = 9'(rem_q);
    if ({21'd0, words_4k} < 32'(beats_d)) beats_d = words_4k[8:0];
  end

  // Burst bookkeeping and read-beat checking with a saturating error counter
  always_comb begin
    last_beat = (beat_q == beats_q - 9'd1);
    rem_d     = rem_q - CW'(beats_q);
    addr_d    = addr_q + 32'({beats_q, 2'b00});
    beat_addr = addr_q + 32'({beat_q, 2'b00});
    exp_word  = seed_q + 32'(idx_q);
    err_inc   = {1'b0, m_axi_rdata != exp_word} + {1'b0, m_axi_rlast != last_beat};
    err_sum   = {1'b0, err_q} + (CW+1)'(err_inc);
    err_d     = err_sum[CW] ? '1 : err_sum[CW-1:0];
  end

  // Test sequencer: write all bursts, then read and compare all bursts
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      seed_q    <= '0;
      ferr_q    <= '0;
      nwords_q  <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      err_q     <= '0;
      beats_q   <= '0;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr & ~32'd3;
            addr_q   <= base_addr & ~32'd3;
            nwords_q <= nwords;
            rem_q    <= nwords;
            seed_q   <= seed;
            idx_q    <= '0;
            err_q    <= '0;
            ferr_q   <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
            if (nwords == '0) begin
              state_q <= S_ZERO;
            end else begin
              awvalid_q <= 1'b1;
              state_q   <= S_WR_AW;
            end
          end
        end
        S_ZERO: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_WR_AW: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beats_q   <= beats_d;
            beat_q    <= '0;
            state_q   <= S_WR_W;
          end
        end
        S_WR_W: begin
          if (m_axi_wready) begin
            idx_q  <= idx_q + CW'(1);
            beat_q <= beat_q + 9'd1;
            if (last_beat) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= S_WR_B;
            end
          end
        end
        S_WR_B: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            if (rem_d != '0) begin
              rem_q     <= rem_d;
              addr_q    <= addr_d;
              awvalid_q <= 1'b1;
              state_q   <= S_WR_AW;
            end else begin
              rem_q     <= nwords_q;
              addr_q    <= base_q;
              idx_q     <= '0;
              arvalid_q <= 1'b1;
              state_q   <= S_RD_AR;
            end
          end
        end
        S_RD_AR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beats_q   <= beats_d;
            beat_q    <= '0;
            state_q   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (m_axi_rvalid) begin
            idx_q  <= idx_q + CW'(1);
            beat_q <= beat_q + 9'd1;
            err_q  <= err_d;
            if (err_q == '0 && err_d != '0) ferr_q <= beat_addr;
            if (last_beat) begin
              rready_q <= 1'b0;
              if (rem_d != '0) begin
                rem_q     <= rem_d;
                addr_q    <= addr_d;
                arvalid_q <= 1'b1;
                state_q   <= S_RD_AR;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                pass_q  <= (err_d == '0);
                state_q <= S_DONE;
              end
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  assign m_axi_awvalid  = awvalid_q;
  assign m_axi_awaddr   = awvalid_q ? addr_q : '0;
  assign m_axi_awlen    = awvalid_q ? 8'(beats_d - 9'd1) : '0;
  assign m_axi_wvalid   = wvalid_q;
  assign m_axi_wdata    = wvalid_q ? exp_word : '0;
  assign m_axi_wstrb    = {4{wvalid_q}};
  assign m_axi_wlast    = wvalid_q & last_beat;
  assign m_axi_bready   = bready_q;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_araddr   = arvalid_q ? addr_q : '0;
  assign m_axi_arlen    = arvalid_q ? 8'(beats_d - 9'd1) : '0;
  assign m_axi_rready   = rready_q;

endmodule

// File: tb/tb_axi_mem_bist.sv
// tb/tb_axi_mem_bist.sv - randomized self-checking bench for axi_mem_bist with a behavioural AXI memory
module tb_axi_mem_bist;

  localparam int MAXB = 16;

  logic        s_aclk, s_aresetn, start;
  logic [31:0] base_addr, seed;
  logic [15:0] nwords;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_mem_bist #(.G_MAXBURST(MAXB), .G_CNTWIDTH(16)) dut (
    .s_aclk(s_aclk), .s_aresetn(s_aresetn), .start(start), .base_addr(base_addr),
    .nwords(nwords), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial s_aclk = 1'b0;
  always #5 s_aclk = ~s_aclk;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:4095];
  int          stall_pct = 0;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  int          viol_s = 0;
  int          viol_m = 0;
  logic [39:0] aw_log[$];
  logic [39:0] ar_log[$];
  logic [39:0] exp_bursts[$];

  // Behavioural slave: AW accepted only when idle, W only after AW, random W/R stalls
  logic [31:0] sl_waddr, sl_raddr;
  int          sl_wleft, sl_rleft;
  logic        sl_w_act, sl_r_act, rv_now;
  always @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      sl_w_act = 1'b0; sl_r_act = 1'b0; sl_wleft = 0; sl_rleft = 0;
      sl_waddr = '0; sl_raddr = '0;
      m_axi_awready <= 1'b1; m_axi_wready <= 1'b0; m_axi_bvalid <= 1'b0;
      m_axi_arready <= 1'b1; m_axi_rvalid <= 1'b0; m_axi_rlast <= 1'b0; m_axi_rdata <= '0;
    end else begin
      if (m_axi_wvalid && m_axi_wready) begin
        if (m_axi_wstrb != 4'hF) viol_s++;
        if (m_axi_wlast != (sl_wleft == 1)) viol_s++;
        mem[sl_waddr[13:2]] = m_axi_wdata;
        sl_waddr += 32'd4;
        sl_wleft--;
        if (sl_wleft == 0) begin sl_w_act = 1'b0; m_axi_bvalid <= 1'b1; end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0; m_axi_awready <= 1'b1;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        sl_waddr = m_axi_awaddr; sl_wleft = int'(m_axi_awlen) + 1; sl_w_act = 1'b1;
        m_axi_awready <= 1'b0;
      end
      m_axi_wready <= sl_w_act && ($urandom_range(99) >= stall_pct);

      rv_now = m_axi_rvalid;
      if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0; rv_now = 1'b0;
        sl_raddr += 32'd4;
        sl_rleft--;
        if (sl_rleft == 0) begin sl_r_act = 1'b0; m_axi_arready <= 1'b1; end
      end
      if (m_axi_arvalid && m_axi_arready) begin
        sl_raddr = m_axi_araddr; sl_rleft = int'(m_axi_arlen) + 1; sl_r_act = 1'b1;
        m_axi_arready <= 1'b0;
      end
      if (sl_r_act && !rv_now && ($urandom_range(99) >= stall_pct)) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= mem[sl_raddr[13:2]] ^ ((sl_raddr == corrupt_addr) ? 32'h0000_0001 : 32'h0);
        m_axi_rlast  <= (sl_rleft == 1);
      end
    end
  end

  // Protocol monitor: burst logging, valid stability, phase exclusivity
  logic aw_hold, w_hold, ar_hold;
  always @(posedge s_aclk) begin
    if (!s_aresetn) begin
      aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
    end else begin
      if (aw_hold && !m_axi_awvalid) viol_m++;
      if (w_hold && !m_axi_wvalid) viol_m++;
      if (ar_hold && !m_axi_arvalid) viol_m++;
      if ((m_axi_awvalid || m_axi_wvalid || m_axi_bready) && (m_axi_arvalid || m_axi_rready)) viol_m++;
      aw_hold <= m_axi_awvalid && !m_axi_awready;
      w_hold  <= m_axi_wvalid && !m_axi_wready;
      ar_hold <= m_axi_arvalid && !m_axi_arready;
      if (m_axi_awvalid && m_axi_awready) aw_log.push_back({m_axi_awaddr, m_axi_awlen});
      if (m_axi_arvalid && m_axi_arready) ar_log.push_back({m_axi_araddr, m_axi_arlen});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference burst list from the page/limit rules, plain arithmetic
  function automatic void model_bursts(input logic [31:0] b, input int n);
    logic [31:0] a;
    int rem, w4k, bt;
    exp_bursts.delete();
    a = b;
    rem = n;
    while (rem > 0) begin
      w4k = (4096 - int'(a % 32'd4096)) / 4;
      bt = rem;
      if (bt > MAXB) bt = MAXB;
      if (bt > w4k) bt = w4k;
      exp_bursts.push_back({a, 8'(bt - 1)});
      a += 32'(4 * bt);
      rem -= bt;
    end
  endfunction

  function automatic logic any_out();
    return |{busy, done, pass, err_count, first_err_addr, m_axi_awaddr, m_axi_awlen,
             m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
             m_axi_bready, m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready};
  endfunction

  task automatic run_test(input string tag, input logic [31:0] b, input int n,
                          input logic [31:0] sd, input logic [31:0] corrupt, input int stall);
    int aw0, ar0, v0, k, exp_err, badw;
    logic [31:0] exp_ferr, a;
    logic got;
    model_bursts(b, n);
    exp_err = 0;
    exp_ferr = '0;
    for (int i = 0; i < n; i++) begin
      a = b + 32'(4 * i);
      if (a == corrupt) begin
        if (exp_err == 0) exp_ferr = a;
        exp_err++;
      end
    end
    aw0 = aw_log.size();
    ar0 = ar_log.size();
    v0 = viol_s + viol_m;
    stall_pct = stall;
    corrupt_addr = corrupt;
    @(negedge s_aclk);
    base_addr = b; nwords = 16'(n); seed = sd; start = 1'b1;
    @(negedge s_aclk);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    chk({tag, "_clr"}, {pass, err_count, first_err_addr}, 64'd0);
    base_addr = 32'h3000; nwords = 16'd7; seed = 32'hDEAD_BEEF;
    got = 1'b0;
    k = 0;
    while (k < 20000) begin
      @(negedge s_aclk);
      start = 1'b0;
      k++;
      if (done) begin got = 1'b1; break; end
    end
    chk({tag, "_done"}, {63'd0, got}, 64'd1);
    if (n == 0) chk({tag, "_lat"}, 64'(k), 64'd1);
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_pass"}, {63'd0, pass}, {63'd0, exp_err == 0});
    chk({tag, "_errcnt"}, {48'd0, err_count}, 64'(exp_err));
    chk({tag, "_ferr"}, {32'd0, first_err_addr}, {32'd0, exp_ferr});
    start = 1'b1; nwords = 16'd3;
    @(negedge s_aclk);
    start = 1'b0;
    chk({tag, "_start_on_done"}, {62'd0, busy, done}, 64'd0);
    chk({tag, "_pass_hold"}, {63'd0, pass}, {63'd0, exp_err == 0});
    chk({tag, "_nwr"}, 64'(aw_log.size() - aw0), 64'(exp_bursts.size()));
    chk({tag, "_nrd"}, 64'(ar_log.size() - ar0), 64'(exp_bursts.size()));
    for (int j = 0; j < exp_bursts.size(); j++) begin
      if (aw0 + j < aw_log.size()) chk({tag, "_aw"}, {24'd0, aw_log[aw0 + j]}, {24'd0, exp_bursts[j]});
      if (ar0 + j < ar_log.size()) chk({tag, "_ar"}, {24'd0, ar_log[ar0 + j]}, {24'd0, exp_bursts[j]});
    end
    badw = 0;
    for (int i = 0; i < n; i++) begin
      a = b + 32'(4 * i);
      if (mem[a[13:2]] !== sd + 32'(i)) badw++;
    end
    chk({tag, "_memfill"}, 64'(badw), 64'd0);
    chk({tag, "_proto"}, 64'(viol_s + viol_m - v0), 64'd0);
  endtask

  initial begin
    logic got;
    start = 1'b0; base_addr = '0; nwords = '0; seed = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    s_aresetn = 1'b0;
    #1;
    chk("reset_outs", {63'd0, any_out()}, 64'd0);
    repeat (3) @(negedge s_aclk);
    s_aresetn = 1'b1;

    run_test("single", 32'h0, 16, 32'h1000_0000, 32'hFFFF_FFFF, 0);
    run_test("three", 32'h0, 40, $urandom, 32'hFFFF_FFFF, 0);
    run_test("page", 32'hFF8, 4, $urandom, 32'hFFFF_FFFF, 0);
    run_test("corrupt", 32'h100, 16, $urandom, 32'h114, 20);
    run_test("zero", 32'h40, 0, $urandom, 32'hFFFF_FFFF, 0);
    for (int r = 0; r < 3; r++)
      run_test("rand", {18'd0, 12'($urandom_range(0, 3071)), 2'b00},
               int'($urandom_range(1, 70)), $urandom, 32'hFFFF_FFFF, int'($urandom_range(0, 60)));

    stall_pct = 50;
    corrupt_addr = 32'hFFFF_FFFF;
    @(negedge s_aclk);
    base_addr = 32'h200; nwords = 16'd40; seed = $urandom; start = 1'b1;
    @(negedge s_aclk);
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge s_aclk);
      if (m_axi_wvalid) begin got = 1'b1; break; end
    end
    chk("midwr_reach", {63'd0, got}, 64'd1);
    #2 s_aresetn = 1'b0;
    #1;
    chk("midwr_reset_outs", {63'd0, any_out()}, 64'd0);
    repeat (2) @(negedge s_aclk);
    s_aresetn = 1'b1;
    run_test("after_rst", 32'h600, 8, $urandom, 32'hFFFF_FFFF, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
